// File: rtl/plic_target_arbiter.sv
// Per-target PLIC arbiter: reduces pending/enabled sources to one winning ID
// through an optionally pipelined comparator tree, with threshold gating and claim/complete tracking.
module plic_target_arbiter #(
    parameter int NUM_SOURCES    = 31,
    parameter int PRIORITY_WIDTH = 3,
    parameter int ID_WIDTH       = $clog2(NUM_SOURCES + 1),
    parameter int PIPELINED      = 1
) (
    input  logic                                   clk_i,
    input  logic                                   rstn_i,
    input  logic [NUM_SOURCES-1:0]                 interrupt_pending_i,
    input  logic [NUM_SOURCES-1:0]                 interrupt_enable_i,
    input  logic [NUM_SOURCES*PRIORITY_WIDTH-1:0]  interrupt_priority_i,
    input  logic [PRIORITY_WIDTH-1:0]              priority_threshold_i,
    input  logic                                   claim_i,
    input  logic                                   complete_i,
    input  logic [ID_WIDTH-1:0]                    complete_id_i,
    output logic                                   irq_o,
    output logic [PRIORITY_WIDTH-1:0]              max_priority_o,
    output logic [ID_WIDTH-1:0]                    max_id_o,
    output logic [ID_WIDTH-1:0]                    claim_id_o,
    output logic [NUM_SOURCES-1:0]                 in_service_o
);

    localparam int LEVELS     = $clog2(NUM_SOURCES + 1);
    localparam int NUM_LEAVES = 1 << LEVELS;
    localparam int NODE_WIDTH = PRIORITY_WIDTH + ID_WIDTH;

    // One-hot source mask for an ID; ID 0 and out-of-range IDs map to an empty mask.
    function automatic logic [NUM_SOURCES-1:0] id_onehot(input logic [ID_WIDTH-1:0] id);
        logic [NUM_SOURCES-1:0] oh;
        oh = {NUM_SOURCES{1'b0}};
        for (int k = 0; k < NUM_SOURCES; k++) begin
            oh[k] = (id == ID_WIDTH'(k + 1));
        end
        return oh;
    endfunction

    // Node is {priority, id}: a plain magnitude compare gives priority first, then greater ID on ties.
    function automatic logic [NODE_WIDTH-1:0] pick(input logic [NODE_WIDTH-1:0] a,
                                                   input logic [NODE_WIDTH-1:0] b);
        logic [NODE_WIDTH-1:0] w;
        if (b > a) begin
            w = b;
        end else begin
            w = a;
        end
        return w;
    endfunction

    logic [NUM_SOURCES-1:0]    in_service_r;
    logic [NUM_SOURCES-1:0]    in_service_next_s;
    logic [ID_WIDTH-1:0]       claim_id_r;
    logic [NODE_WIDTH-1:0]     node_s [1:2*NUM_LEAVES-1];
    logic [PRIORITY_WIDTH-1:0] root_prio_s;
    logic [ID_WIDTH-1:0]       root_id_s;
    logic                      root_stale_s;

    // Heap-indexed tree: node n has children 2n and 2n+1; leaves sit at NUM_LEAVES + slot.
    for (genvar s = 0; s < NUM_LEAVES; s++) begin : g_leaf
        if (s >= 1 && s <= NUM_SOURCES) begin : g_src
            logic [PRIORITY_WIDTH-1:0] prio_s;
            logic                      eligible_s;
            assign prio_s     = interrupt_priority_i[(s-1)*PRIORITY_WIDTH +: PRIORITY_WIDTH];
            assign eligible_s = interrupt_pending_i[s-1] & interrupt_enable_i[s-1]
                              & ~in_service_r[s-1] & (prio_s != {PRIORITY_WIDTH{1'b0}});
            assign node_s[NUM_LEAVES+s] = eligible_s ? {prio_s, ID_WIDTH'(s)}
                                                     : {NODE_WIDTH{1'b0}};
        end else begin : g_tie
            assign node_s[NUM_LEAVES+s] = {NODE_WIDTH{1'b0}};
        end
    end

    for (genvar n = 1; n < NUM_LEAVES; n++) begin : g_node
        logic [NODE_WIDTH-1:0] pick_s;
        assign pick_s = pick(node_s[2*n], node_s[2*n+1]);
        if (PIPELINED != 0 || n == 1) begin : g_reg
            logic [NODE_WIDTH-1:0] node_r;
            // Tree stage register; the root is always registered.
            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    node_r <= {NODE_WIDTH{1'b0}};
                end else begin
                    node_r <= pick_s;
                end
            end
            assign node_s[n] = node_r;
        end else begin : g_comb
            assign node_s[n] = pick_s;
        end
    end

    assign root_prio_s  = node_s[1][NODE_WIDTH-1 -: PRIORITY_WIDTH];
    assign root_id_s    = node_s[1][ID_WIDTH-1:0];
    assign root_stale_s = |(in_service_r & id_onehot(root_id_s));

    // Suppress an in-flight winner that has already been claimed.
    always_comb begin
        max_id_o       = {ID_WIDTH{1'b0}};
        max_priority_o = {PRIORITY_WIDTH{1'b0}};
        if (root_stale_s) begin
            max_id_o       = {ID_WIDTH{1'b0}};
            max_priority_o = {PRIORITY_WIDTH{1'b0}};
        end else begin
            max_id_o       = root_id_s;
            max_priority_o = root_prio_s;
        end
    end

    assign irq_o = (max_id_o != {ID_WIDTH{1'b0}}) && (max_priority_o > priority_threshold_i);

    // Next in-service mask: complete clears, claim of a nonzero winner sets.
    always_comb begin
        in_service_next_s = in_service_r;
        if (complete_i) begin
            in_service_next_s = in_service_next_s & ~id_onehot(complete_id_i);
        end else begin
            in_service_next_s = in_service_next_s;
        end
        if (claim_i) begin
            in_service_next_s = in_service_next_s | id_onehot(max_id_o);
        end else begin
            in_service_next_s = in_service_next_s;
        end
    end

    // In-service and claim-ID state.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            in_service_r <= {NUM_SOURCES{1'b0}};
            claim_id_r   <= {ID_WIDTH{1'b0}};
        end else begin
            in_service_r <= in_service_next_s;
            if (claim_i) begin
                claim_id_r <= max_id_o;
            end else begin
                claim_id_r <= claim_id_r;
            end
        end
    end

    assign in_service_o = in_service_r;
    assign claim_id_o   = claim_id_r;

endmodule
